qenc_speed: RTL
===============

QENC_SPEED -- requirements
Module: qenc_speed

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the signed position/speed width (range 8..32).
REQ-002 The block SHALL have parameter GATE_W, default 16, giving the speed gate-length width.
REQ-003 The block SHALL have parameter FILT_LEN, default 4, giving the glitch-filter stability count in clk cycles (range 2..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of position, window accumulator and gate counter.
REQ-007 The block SHALL have port gate_len, input, GATE_W bits: speed window length in clk cycles; 0 disables speed measurement.
REQ-008 The block SHALL have ports phA and phB, input, 1 bit each: asynchronous quadrature phases.
REQ-009 The block SHALL have port dir, output, 1 bit: direction of the last valid step, 1 = forward.
REQ-010 The block SHALL have port pos, output, CNT_W bits: signed, saturating position count.
REQ-011 The block SHALL have port speed, output, CNT_W bits: signed step count of the last completed window.
REQ-012 The block SHALL have port speed_vld, output, 1 bit: one-cycle pulse when speed updates.
REQ-013 The block SHALL have ports upOf and downOf, output, 1 bit each: high while pos sits at +MAX or -MAX.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse on an illegal double-phase transition.

Function
REQ-015 phA/phB SHALL pass through a 2-flop synchroniser before any other use.
REQ-016 Forward sequence SHALL be {A,B} = 00->10->11->01->00; each forward step adds +1, each reverse step adds -1, and dir is set accordingly.
REQ-017 A transition changing both phases in one sample SHALL pulse err, produce no count, and leave dir unchanged.
REQ-018 pos SHALL saturate at +MAX = 2^(CNT_W-1)-1 and at -MAX = -(2^(CNT_W-1)-1); a step beyond the limit SHALL hold pos, with no wrap.
REQ-019 A legal phase change SHALL appear on pos exactly 3 clk cycles after the raw input edge (2 sync + 1 register).
REQ-020 The gate counter SHALL count 0..gate_len-1; in its terminal cycle, speed <= window accumulator + current step, the accumulator <= 0, and speed_vld = 1 for that cycle.
REQ-021 The window accumulator SHALL saturate at +/-MAX using the same rule as pos.
REQ-022 When gate_len = 0, the gate counter and accumulator SHALL hold at 0, speed SHALL hold, and speed_vld SHALL stay 0.
REQ-023 A change of gate_len mid-window SHALL take effect on the counter compare immediately; if counter >= new gate_len-1, the window terminates in that cycle.
REQ-024 clr SHALL zero pos, the accumulator and the gate counter, SHALL override any coincident step or terminal event, and SHALL leave speed and dir unchanged.

Reset
REQ-025 On rst = 1 at a clk edge, the block SHALL clear pos, speed, the accumulator, the gate counter, dir, speed_vld, err and the synchroniser/filter state to 0; upOf and downOf SHALL then read 0.
REQ-026 rst SHALL take priority over clr and all other activity, including a mid-window reset.

Configuration
REQ-027 With macro QENC_GLITCH_FILTER_EN defined, each synchronised phase SHALL be accepted only after FILT_LEN consecutive equal samples, adding FILT_LEN cycles to the latency in REQ-019.
REQ-028 Without QENC_GLITCH_FILTER_EN, the synchronised phases SHALL feed the decoder directly, with latency exactly as in REQ-019.

Structure
REQ-029 A shared package qenc_pkg SHALL hold the phase-state encoding constants, the step codes (NONE/FWD/REV/ILLEGAL) and the saturating-add helper.
REQ-030 A single sub-module qenc_filter (one instance per phase, generated only under the macro) SHALL implement the glitch filter.

Verification
REQ-031 Bench SHALL cover: 8 forward steps from reset -> pos = 8, dir = 1, err never asserted; then 3 reverse steps -> pos = 5, dir = 0.
REQ-032 Bench SHALL cover: CNT_W = 8, 130 forward steps -> pos = 127, upOf = 1; one reverse step -> pos = 126, upOf = 0; 260 reverse steps -> pos = -127, downOf = 1.
REQ-033 Bench SHALL cover: gate_len = 100, 10 forward steps inside the window -> speed_vld pulses once at cycle 99 with speed = 10; next window with 0 steps -> speed = 0.
REQ-034 Bench SHALL cover: {A,B} 00->11 -> err pulses for 1 cycle and pos is unchanged; also clr coincident with a step -> pos = 0.
REQ-035 Bench SHALL cover: with the macro defined and FILT_LEN = 4, a 3-cycle phA glitch -> no count; a 5-cycle-stable edge -> pos +1 at 7 cycles.
REQ-036 Bench SHALL cover: rst asserted mid-window with pos = 20 -> next cycle all outputs 0, and no speed_vld pulse.

Source files
------------

// File: rtl/qenc_pkg.sv
// Shared quadrature-decoder definitions: phase encodings, step codes and the
// saturating accumulate helper used for both position and speed window.
package qenc_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;

   typedef enum logic [1:0] {
      STEP_NONE    = 2'd0,
      STEP_FWD     = 2'd1,
      STEP_REV     = 2'd2,
      STEP_ILLEGAL = 2'd3
   } step_t;

   // Position of a phase pair along the forward cycle 00->10->11->01.
   function automatic logic [1:0] phaseIdx(input logic [1:0] ab);
      logic [1:0] idx;
      case (ab)
         PH_00:   idx = 2'd0;
         PH_10:   idx = 2'd1;
         PH_11:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   function automatic step_t decodeStep(input logic [1:0] prevAb, input logic [1:0] curAb);
      logic [1:0] d;
      step_t      s;
      d = phaseIdx(curAb) - phaseIdx(prevAb);
      case (d)
         2'd0:    s = STEP_NONE;
         2'd1:    s = STEP_FWD;
         2'd3:    s = STEP_REV;
         default: s = STEP_ILLEGAL;
      endcase
      return s;
   endfunction

   // Symmetric clamp to +/-lim; one extra bit keeps the sum exact at 32-bit widths.
   function automatic logic signed [31:0] satAdd(input logic signed [31:0] a,
                                                 input logic signed [1:0]  b,
                                                 input logic signed [31:0] lim);
      logic signed [32:0] s;
      logic signed [31:0] r;
      s = 33'(a) + 33'(b);
      if (s > 33'(lim))
         r = lim;
      else if (s < -33'(lim))
         r = -lim;
      else
         r = s[31:0];
      return r;
   endfunction

endpackage

// File: rtl/qenc_filter.sv
// Per-phase glitch filter: output follows the input only after FILT_LEN
// consecutive samples that disagree with the current output.
`ifdef QENC_GLITCH_FILTER_EN
module qenc_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (din == dout) begin
         cnt <= '0;
      end else if (cnt == 4'(FILT_LEN - 1)) begin
         dout <= din;
         cnt  <= '0;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end

endmodule
`endif

// File: rtl/qenc_speed.sv
// Quadrature encoder position counter with gated speed measurement.
// Optional per-phase glitch filter enabled by macro QENC_GLITCH_FILTER_EN.
module qenc_speed
   import qenc_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int GATE_W   = 16,
   parameter int FILT_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              phA,
   input  logic              phB,
   output logic              dir,
   output logic [CNT_W-1:0]  pos,
   output logic [CNT_W-1:0]  speed,
   output logic              speed_vld,
   output logic              upOf,
   output logic              downOf,
   output logic              err
);

   localparam logic [32:0]        ONE33   = 33'd1;
   localparam logic signed [31:0] MAXV    = 32'((ONE33 << (CNT_W - 1)) - ONE33);
   localparam logic [CNT_W-1:0]   POS_MAX = MAXV[CNT_W-1:0];
   localparam logic [CNT_W-1:0]   NEG_MAX = CNT_W'(-MAXV);

   logic [1:0]        syncA;
   logic [1:0]        syncB;
   logic              phAf;
   logic              phBf;
   logic [1:0]        prevAb;
   logic [1:0]        curAb;
   step_t             step;
   logic signed [1:0] inc;
   logic [CNT_W-1:0]  acc;
   logic [GATE_W-1:0] gateCnt;
   logic              terminal;

   always_ff @(posedge clk) begin
      if (rst) begin
         syncA <= '0;
         syncB <= '0;
      end else begin
         syncA <= {syncA[0], phA};
         syncB <= {syncB[0], phB};
      end
   end

`ifdef QENC_GLITCH_FILTER_EN
   qenc_filter #(.FILT_LEN(FILT_LEN)) uFiltA (.clk(clk), .rst(rst), .din(syncA[1]), .dout(phAf));
   qenc_filter #(.FILT_LEN(FILT_LEN)) uFiltB (.clk(clk), .rst(rst), .din(syncB[1]), .dout(phBf));
`else
   assign phAf = syncA[1];
   assign phBf = syncB[1];
`endif

   assign curAb = {phAf, phBf};
   assign step  = decodeStep(prevAb, curAb);

   always_comb begin
      inc = '0;
      case (step)
         STEP_FWD: inc = 2'sb01;
         STEP_REV: inc = 2'sb11;
         default:  ;
      endcase
   end

   // A shrinking gate_len can leave the counter past the new end; close the window at once.
   assign terminal = (gate_len != '0) && (gateCnt >= gate_len - GATE_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         prevAb    <= '0;
         err       <= 1'b0;
         speed_vld <= 1'b0;
         dir       <= 1'b0;
         pos       <= '0;
         speed     <= '0;
         acc       <= '0;
         gateCnt   <= '0;
      end else begin
         prevAb    <= curAb;
         err       <= (step == STEP_ILLEGAL);
         speed_vld <= 1'b0;
         if (clr) begin
            pos     <= '0;
            acc     <= '0;
            gateCnt <= '0;
         end else begin
            if (step == STEP_FWD)
               dir <= 1'b1;
            else if (step == STEP_REV)
               dir <= 1'b0;
            pos <= CNT_W'(satAdd(32'($signed(pos)), inc, MAXV));
            if (gate_len == '0) begin
               acc     <= '0;
               gateCnt <= '0;
            end else if (terminal) begin
               speed     <= CNT_W'(satAdd(32'($signed(acc)), inc, MAXV));
               acc       <= '0;
               gateCnt   <= '0;
               speed_vld <= 1'b1;
            end else begin
               acc     <= CNT_W'(satAdd(32'($signed(acc)), inc, MAXV));
               gateCnt <= gateCnt + GATE_W'(1);
            end
         end
      end
   end

   assign upOf   = (pos == POS_MAX);
   assign downOf = (pos == NEG_MAX);

endmodule
